// File: rtl/aska_spi_cfg_seq.sv
// Power-on sequencer and SPI Mode 0 configuration master for the aska_dig test target.
// Holds porborn low after reset, then shifts accepted words out MSB-first with CS framing.
module aska_spi_cfg_seq #(
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 12,
    parameter int CS_GAP     = 25,
    parameter int POR_CYCLES = 250
) (
    input  logic                  clk_25mhz,
    input  logic                  resetn,
    input  logic                  cfg_valid,
    input  logic [FRAME_BITS-1:0] cfg_word,
    output logic                  cfg_ready,
    input  logic                  abort,
    output logic                  porborn,
    output logic                  spi_cs,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  busy,
    output logic [7:0]            frames_sent
);

    localparam int MAX_A   = (POR_CYCLES > CLK_DIV) ? POR_CYCLES : CLK_DIV;
    localparam int MAX_CNT = (MAX_A > CS_GAP) ? MAX_A : CS_GAP;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int HALF_W  = $clog2(2 * FRAME_BITS + 1);

    localparam logic [CNT_W-1:0]  POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);
    localparam logic [HALF_W-1:0] HALF_END  = HALF_W'(2 * FRAME_BITS);
    localparam logic [HALF_W-1:0] LAST_FALL = HALF_W'(2 * FRAME_BITS - 1);

    typedef enum logic [1:0] {POR, IDLE, SHIFT, GAP} state_t;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [HALF_W-1:0]       half, half_d;
    logic [FRAME_BITS-1:0]   sreg, sreg_d;
    logic                    porborn_d, cs_d, clk_d, mosi_d, ready_d, busy_d;
    logic [7:0]              frames_d;

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state       <= POR;
            cnt         <= '0;
            half        <= '0;
            sreg        <= '0;
            porborn     <= 1'b0;
            spi_cs      <= 1'b1;
            spi_clk     <= 1'b0;
            spi_mosi    <= 1'b0;
            cfg_ready   <= 1'b0;
            busy        <= 1'b1;
            frames_sent <= 8'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            half        <= half_d;
            sreg        <= sreg_d;
            porborn     <= porborn_d;
            spi_cs      <= cs_d;
            spi_clk     <= clk_d;
            spi_mosi    <= mosi_d;
            cfg_ready   <= ready_d;
            busy        <= busy_d;
            frames_sent <= frames_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        half_d    = half;
        sreg_d    = sreg;
        porborn_d = porborn;
        cs_d      = spi_cs;
        clk_d     = spi_clk;
        mosi_d    = spi_mosi;
        frames_d  = frames_sent;

        case (state)
            POR: begin
                if (cnt == POR_LAST) begin
                    porborn_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    sreg_d  = cfg_word;
                    state_d = SHIFT;
                    cnt_d   = '0;
                    half_d  = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    cs_d    = 1'b1;
                    clk_d   = 1'b0;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (spi_cs) begin
                    // First SHIFT cycle: CS falls and the MSB is presented together.
                    cs_d   = 1'b0;
                    mosi_d = sreg[FRAME_BITS-1];
                    cnt_d  = '0;
                end else if (cnt == DIV_LAST) begin
                    cnt_d  = '0;
                    half_d = half + 1'b1;
                    if (half == HALF_END) begin
                        cs_d     = 1'b1;
                        mosi_d   = 1'b0;
                        frames_d = frames_sent + 8'd1;
                        state_d  = GAP;
                    end else if (!half[0]) begin
                        clk_d = 1'b1;
                    end else begin
                        clk_d = 1'b0;
                        // The final bit stays on MOSI until CS rises.
                        if (half != LAST_FALL) begin
                            sreg_d = sreg << 1;
                            mosi_d = sreg_d[FRAME_BITS-1];
                        end
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = POR;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: tb/tb_aska_spi_cfg_seq.sv
// Directed bench for aska_spi_cfg_seq: a default-parameter instance with an SPI slave
// monitor, plus a fast small instance used to wrap the frame counter.
module tb_aska_spi_cfg_seq;

    logic        clk_25mhz = 1'b0;
    logic        resetn    = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_word  = 16'h0000;
    logic        abort     = 1'b0;
    logic        cfg_ready, porborn, spi_cs, spi_clk, spi_mosi, busy;
    logic [7:0]  frames_sent;

    logic        s_valid = 1'b0;
    logic [3:0]  s_word  = 4'h9;
    logic        s_abort = 1'b0;
    logic        s_ready, s_porborn, s_cs, s_clk, s_mosi, s_busy;
    logic [7:0]  s_frames;

    always #20 clk_25mhz = ~clk_25mhz;

    aska_spi_cfg_seq u_dut (
        .clk_25mhz  (clk_25mhz),
        .resetn     (resetn),
        .cfg_valid  (cfg_valid),
        .cfg_word   (cfg_word),
        .cfg_ready  (cfg_ready),
        .abort      (abort),
        .porborn    (porborn),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .busy       (busy),
        .frames_sent(frames_sent)
    );

    aska_spi_cfg_seq #(.FRAME_BITS(4), .CLK_DIV(1), .CS_GAP(2), .POR_CYCLES(3)) u_small (
        .clk_25mhz  (clk_25mhz),
        .resetn     (resetn),
        .cfg_valid  (s_valid),
        .cfg_word   (s_word),
        .cfg_ready  (s_ready),
        .abort      (s_abort),
        .porborn    (s_porborn),
        .spi_cs     (s_cs),
        .spi_clk    (s_clk),
        .spi_mosi   (s_mosi),
        .busy       (s_busy),
        .frames_sent(s_frames)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // SPI slave model for the default instance, sampled on the falling system clock edge
    int          cyc = 0;
    logic        cs_q = 1'b1, clk_q = 1'b0;
    int          fall_cyc = 0, rise_cyc = 0, low_len = 0, nbits = 0;
    int          first_off = 0, last_rise = 0, spacing_bad = 0, stray_rise = 0, done_cnt = 0;
    logic [15:0] cap = 16'h0;

    always @(negedge clk_25mhz) begin
        cyc   <= cyc + 1;
        cs_q  <= spi_cs;
        clk_q <= spi_clk;
        if (cs_q && !spi_cs) begin
            fall_cyc <= cyc;
            nbits    <= 0;
            cap      <= 16'h0;
        end
        if (!clk_q && spi_clk) begin
            if (spi_cs) begin
                stray_rise <= stray_rise + 1;
            end else begin
                cap   <= {cap[14:0], spi_mosi};
                nbits <= nbits + 1;
                if (nbits == 0) first_off <= cyc - fall_cyc;
                else if (cyc - last_rise != 24) spacing_bad <= spacing_bad + 1;
                last_rise <= cyc;
            end
        end
        if (!cs_q && spi_cs) begin
            low_len  <= cyc - fall_cyc;
            rise_cyc <= cyc;
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic wait_ready(input string tag);
        int b = 0;
        while (!cfg_ready && b < 2000) begin
            @(negedge clk_25mhz);
            b++;
        end
        if (b >= 2000) check(tag, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [15:0] w, input string tag);
        wait_ready(tag);
        cfg_word  = w;
        cfg_valid = 1'b1;
        @(posedge clk_25mhz);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string tag);
        int b = 0;
        while (done_cnt == prev && b < 2000) begin
            @(negedge clk_25mhz);
            b++;
        end
        if (b >= 2000) check(tag, 32'd0, 32'd1);
    endtask

    task automatic por_window(input string tag);
        int zeros = 0, bad = 0, cs_low = 0;
        for (int i = 0; i < 300; i++) begin
            if (!porborn) zeros++;
            if (cfg_ready !== porborn) bad++;
            if (!spi_cs) cs_low++;
            @(negedge clk_25mhz);
        end
        check({tag, "_por_low_cycles"}, 32'(zeros), 32'd250);
        check({tag, "_ready_vs_por"}, 32'(bad), 32'd0);
        check({tag, "_cs_low_in_por"}, 32'(cs_low), 32'd0);
    endtask

    initial begin
        int prev, r, c, b;
        int rises, viol, s_low, spacing, f255, low_start, last_r, sb;
        logic prev_cs;

        #1 resetn = 1'b0;
        repeat (3) @(negedge clk_25mhz);
        check("rst_porborn", 32'(porborn), 32'd0);
        check("rst_spi_cs", 32'(spi_cs), 32'd1);
        check("rst_spi_clk", 32'(spi_clk), 32'd0);
        check("rst_spi_mosi", 32'(spi_mosi), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_frames", 32'(frames_sent), 32'd0);

        resetn = 1'b1;
        por_window("boot");
        check("boot_busy", 32'(busy), 32'd0);

        // Single frame
        prev = done_cnt;
        send(16'hA5C3, "a5c3_ready_timeout");
        wait_done(prev, "a5c3_done_timeout");
        check("a5c3_capture", 32'(cap), 32'h0000A5C3);
        check("a5c3_bits", 32'(nbits), 32'd16);
        check("a5c3_cs_low", 32'(low_len), 32'd396);
        check("a5c3_first_rise", 32'(first_off), 32'd12);
        check("a5c3_rise_spacing", 32'(spacing_bad), 32'd0);
        check("a5c3_frames", 32'(frames_sent), 32'd1);
        check("a5c3_mosi_idle", 32'(spi_mosi), 32'd0);

        // Back-to-back with cfg_valid held high
        wait_ready("b2b_ready_timeout");
        prev      = done_cnt;
        cfg_word  = 16'h0001;
        cfg_valid = 1'b1;
        @(posedge clk_25mhz);
        #1 cfg_word = 16'hFFFF;
        wait_done(prev, "b2b_first_timeout");
        check("b2b_first_capture", 32'(cap), 32'h00000001);
        r = rise_cyc;
        check("b2b_ready_in_gap", 32'(cfg_ready), 32'd0);
        wait_ready("b2b_second_ready_timeout");
        c = cyc;
        check("b2b_accept_delay", 32'(c - r + 1), 32'd26);
        prev = done_cnt;
        @(posedge clk_25mhz);
        #1 cfg_valid = 1'b0;
        wait_done(prev, "b2b_second_timeout");
        check("b2b_second_capture", 32'(cap), 32'h0000FFFF);
        check("b2b_frames", 32'(frames_sent), 32'd3);

        // Abort after the 5th rising edge
        prev = done_cnt;
        send(16'h1234, "abort_ready_timeout");
        b = 0;
        while (nbits != 5 && b < 2000) begin
            @(negedge clk_25mhz);
            b++;
        end
        if (b >= 2000) check("abort_bits_timeout", 32'd0, 32'd1);
        abort = 1'b1;
        @(posedge clk_25mhz);
        #1 abort = 1'b0;
        check("abort_cs_next_edge", 32'(spi_cs), 32'd1);
        check("abort_clk_low", 32'(spi_clk), 32'd0);
        wait_done(prev, "abort_done_timeout");
        check("abort_bits", 32'(nbits), 32'd5);
        check("abort_partial", 32'(cap), 32'h00000002);
        check("abort_cs_low", 32'(low_len), 32'd110);
        check("abort_frames", 32'(frames_sent), 32'd3);
        prev = done_cnt;
        send(16'h00FF, "after_abort_ready_timeout");
        wait_done(prev, "after_abort_done_timeout");
        check("after_abort_capture", 32'(cap), 32'h000000FF);
        check("after_abort_frames", 32'(frames_sent), 32'd4);

        // Reset in the middle of a frame
        send(16'h5A5A, "midrst_ready_timeout");
        b = 0;
        while (nbits != 3 && b < 2000) begin
            @(negedge clk_25mhz);
            b++;
        end
        if (b >= 2000) check("midrst_bits_timeout", 32'd0, 32'd1);
        #5 resetn = 1'b0;
        #1;
        check("midrst_cs", 32'(spi_cs), 32'd1);
        check("midrst_clk", 32'(spi_clk), 32'd0);
        check("midrst_porborn", 32'(porborn), 32'd0);
        check("midrst_frames", 32'(frames_sent), 32'd0);
        check("midrst_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk_25mhz);
        resetn = 1'b1;
        por_window("midrst");
        check("no_stray_clk", 32'(stray_rise), 32'd0);

        // Frame counter wrap on the small instance, cfg_valid held high throughout
        rises = 0; viol = 0; s_low = 0; spacing = 0; f255 = 0;
        low_start = 0; last_r = 0; sb = 0; prev_cs = s_cs;
        s_valid = 1'b1;
        while (rises < 256 && sb < 6000) begin
            @(negedge clk_25mhz);
            sb++;
            if (s_ready && s_busy) viol++;
            if (s_cs && s_busy && s_porborn && s_ready) viol++;
            if (prev_cs && !s_cs) low_start = sb;
            if (!prev_cs && s_cs) begin
                rises++;
                if (rises == 1) s_low = sb - low_start;
                if (rises == 2) spacing = sb - last_r;
                if (rises == 255) f255 = 32'(s_frames);
                last_r = sb;
            end
            prev_cs = s_cs;
        end
        s_valid = 1'b0;
        check("wrap_frames_done", 32'(rises), 32'd256);
        check("wrap_at_255", 32'(f255), 32'd255);
        check("wrap_to_zero", 32'(s_frames), 32'd0);
        check("small_cs_low", 32'(s_low), 32'd9);
        check("small_rise_spacing", 32'(spacing), 32'd13);
        check("gap_holdoff", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
